slave_i2c: RTL and testbench

SLAVE_I2C -- requirements
Module: slave_i2c

---
 rtl/slave_i2c.sv | 180 ++++++++++++++++++
 tb/tb_slave_i2c.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/slave_i2c.sv
// rtl/slave_i2c.sv - I2C target: address match, byte receive/transmit, ACK handling
// Build option SLAVE_CLK_STRETCH_EN: hold SCL low at each read byte load until tx_valid_i.
module slave_i2c #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_req_o,
  output logic       busy_o,
  output logic       start_o,
  output logic       stop_o
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE
  } state_t;

  state_t        state, state_nxt;
  logic [NS-1:0] scl_sync, sda_sync;
  logic          scl_prev, sda_prev, scl_s, sda_s;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]    bit_cnt;
  logic [6:0]    shreg;
  logic [7:0]    tx_byte;
  logic          rw, last_bit, addr_match;
  logic          byte_load, sda_drive, tx_capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[NS-2:0], scl_in};
      sda_sync <= {sda_sync[NS-2:0], sda_in};
      scl_prev <= scl_sync[NS-1];
      sda_prev <= sda_sync[NS-1];
    end
  end

  assign scl_s      = scl_sync[NS-1];
  assign sda_s      = sda_sync[NS-1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign start_det  = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det   = scl_s & scl_prev & ~sda_prev & sda_s;
  assign last_bit   = (bit_cnt == 4'd0);
  // shreg holds the first seven address bits when the R/W bit arrives
  assign addr_match = (shreg == SLAVE_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else if (scl_rise) begin
      case (state)
        ADDR:     if (last_bit) state_nxt = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: state_nxt = rw ? TX_DATA : RX_DATA;
        RX_DATA:  if (last_bit) state_nxt = RX_ACK;
        RX_ACK:   state_nxt = RX_DATA;
        TX_DATA:  if (last_bit) state_nxt = TX_ACK;
        TX_ACK:   state_nxt = sda_s ? IGNORE : TX_DATA;
        default:  state_nxt = state;
      endcase
    end
  end

`ifdef SLAVE_CLK_STRETCH_EN
  logic load_pend, stretch_q;

  // A read byte is only fetched once SCL is low; SCL is held until the data is offered.
  always_ff @(posedge clk) begin
    if (rst || start_det || stop_det) begin
      load_pend <= 1'b0;
      stretch_q <= 1'b0;
    end else begin
      if (byte_load)            load_pend <= 1'b1;
      if (scl_fall && load_pend) stretch_q <= 1'b1;
      if (stretch_q && tx_valid_i) begin
        stretch_q <= 1'b0;
        load_pend <= 1'b0;
      end
    end
  end

  assign tx_capture = stretch_q & tx_valid_i;
  assign scl_oe     = stretch_q;
  assign tx_req_o   = stretch_q;
`else
  logic load_pend, unused_tx_valid;

  assign load_pend       = 1'b0;
  assign tx_capture      = byte_load;
  assign scl_oe          = 1'b0;
  assign tx_req_o        = byte_load & ~rst;
  assign unused_tx_valid = tx_valid_i;
`endif

  always_comb begin
    byte_load = 1'b0;
    sda_drive = 1'b0;
    if (scl_rise && !start_det && !stop_det)
      byte_load = (state == ADDR_ACK && rw) || (state == TX_ACK && !sda_s);
    case (state)
      ADDR_ACK, RX_ACK: sda_drive = 1'b1;
      TX_DATA:          sda_drive = ~tx_byte[bit_cnt[2:0]] & ~load_pend;
      default:          sda_drive = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 4'd7;
      shreg      <= '0;
      rw         <= 1'b0;
      tx_byte    <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      start_o    <= start_det;
      stop_o     <= stop_det;
      if (start_det || stop_det) begin
        bit_cnt <= 4'd7;
        busy_o  <= 1'b0;
        sda_oe  <= 1'b0;
      end else begin
        if (scl_rise) begin
          if ((state == ADDR || state == RX_DATA || state == TX_DATA) && !last_bit)
            bit_cnt <= bit_cnt - 4'd1;
          if (state == ADDR_ACK || state == RX_ACK || state == TX_ACK)
            bit_cnt <= 4'd7;
          if (state == ADDR || state == RX_DATA)
            shreg <= {shreg[5:0], sda_s};
          if (state == ADDR && last_bit) begin
            rw     <= sda_s;
            busy_o <= addr_match;
          end
          if (state == RX_DATA && last_bit) begin
            rx_data_o  <= {shreg, sda_s};
            rx_valid_o <= 1'b1;
          end
          if (state == TX_ACK && sda_s)
            busy_o <= 1'b0;
        end
        // SDA only moves while SCL is low, one cycle after its falling edge
        if (scl_fall)
          sda_oe <= sda_drive;
        if (tx_capture)
          tx_byte <= tx_data_i;
        if (tx_capture && load_pend)
          sda_oe <= ~tx_data_i[7];
      end
    end
  end

endmodule

// File: tb/tb_slave_i2c.sv
// tb/tb_slave_i2c.sv - directed bench for slave_i2c acting as I2C initiator on an open-drain bus
module tb_slave_i2c;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       sda_oe, scl_oe, rx_valid_o, tx_req_o, busy_o, start_o, stop_o;
  logic [7:0] rx_data_o;
  logic       scl_in, sda_in;

  assign scl_in = scl_m & ~scl_oe;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  slave_i2c dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .scl_oe     (scl_oe),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_req_o   (tx_req_o),
    .busy_o     (busy_o),
    .start_o    (start_o),
    .stop_o     (stop_o)
  );

  int n_cmp = 0, n_fail = 0;
  int n_rx = 0, n_req = 0, n_start = 0, n_stop = 0, n_sda = 0, n_scl = 0, n_busy = 0;
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (rx_valid_o) begin
      n_rx++;
      last_rx = rx_data_o;
    end
    if (tx_req_o) n_req++;
    if (start_o)  n_start++;
    if (stop_o)   n_stop++;
    if (sda_oe)   n_sda++;
    if (scl_oe)   n_scl++;
    if (busy_o)   n_busy++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    r = sda_in;
    scl_m = 1'b0;
    cyc(2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b0;
    cyc(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    sda_m = 1'b1;
    cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read8(output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      v[i] = r;
    end
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] v;
    int         s_rx, s_req, s_start, s_stop, s_sda, s_busy;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data_i = 8'h00; tx_valid_i = 1'b0;
    cyc(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rx_data", rx_data_o, 8'h00);
    chk("rst_pulses", {rx_valid_o, tx_req_o, start_o, stop_o}, 0);
    rst = 1'b0;
    cyc(5);

    // write 0xA5 to 0x50
    s_rx = n_rx; s_start = n_start; s_stop = n_stop;
    i2c_start();
    write_byte(8'hA0, ack);
    chk("wr_addr_ack", ack, 0);
    chk("wr_busy", busy_o, 1);
    write_byte(8'hA5, ack);
    chk("wr_data_ack", ack, 0);
    i2c_stop();
    chk("wr_rx_count", n_rx - s_rx, 1);
    chk("wr_rx_data", last_rx, 8'hA5);
    chk("wr_start_count", n_start - s_start, 1);
    chk("wr_stop_count", n_stop - s_stop, 1);
    chk("wr_busy_after", busy_o, 0);
    chk("wr_sda_after", sda_oe, 0);

    // wrong address 0x51
    s_rx = n_rx; s_sda = n_sda; s_busy = n_busy;
    i2c_start();
    write_byte(8'hA2, ack);
    chk("bad_addr_nack", ack, 1);
    write_byte(8'hFF, ack);
    chk("bad_data_nack", ack, 1);
    i2c_stop();
    chk("bad_sda_cycles", n_sda - s_sda, 0);
    chk("bad_rx_count", n_rx - s_rx, 0);
    chk("bad_busy_cycles", n_busy - s_busy, 0);

    // read two bytes, ACK then NACK
    s_req = n_req;
    tx_data_i = 8'h3C;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("rd_addr_ack", ack, 0);
    read8(v);
    chk("rd_byte0", v, 8'h3C);
    tx_data_i = 8'hC3;
    clk_bit(1'b0, r);
    read8(v);
    chk("rd_byte1", v, 8'hC3);
    clk_bit(1'b1, r);
    cyc(4);
    chk("rd_sda_released", sda_oe, 0);
    chk("rd_busy_nack", busy_o, 0);
    i2c_stop();
    chk("rd_req_count", n_req - s_req, 2);

    // write then repeated START into read
    s_rx = n_rx; s_start = n_start;
    i2c_start();
    write_byte(8'hA0, ack);
    chk("sr_wr_ack", ack, 0);
    write_byte(8'h12, ack);
    chk("sr_data_ack", ack, 0);
    chk("sr_rx_data", last_rx, 8'h12);
    tx_data_i = 8'h5A;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("sr_rd_ack", ack, 0);
    read8(v);
    chk("sr_rd_byte", v, 8'h5A);
    clk_bit(1'b1, r);
    i2c_stop();
    chk("sr_start_count", n_start - s_start, 2);
    chk("sr_rx_count", n_rx - s_rx, 1);

    // reset in the middle of the 4th data bit
    i2c_start();
    write_byte(8'hA0, ack);
    chk("mr_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q / 2);
    rst = 1'b1;
    cyc(1);
    chk("mr_sda_oe", sda_oe, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_rx_data", rx_data_o, 8'h00);
    chk("mr_pulses", {rx_valid_o, tx_req_o, start_o, stop_o}, 0);
    rst = 1'b0;
    scl_m = 1'b0;
    cyc(Q);
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack);
    chk("mr_readdr_ack", ack, 0);
    write_byte(8'h77, ack);
    chk("mr_data_ack", ack, 0);
    i2c_stop();
    chk("mr_rx_data_after", last_rx, 8'h77);

    chk("scl_never_stretched", n_scl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
